// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Optional saturation on overflow is enabled with ADDSUB_SAT_EN.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int digits_f(input int n, input int d);
    return n / d;
  endfunction

  // The counter needs at least one bit even for a single-digit build.
  function automatic int cnt_w_f(input int n, input int d);
    return (n / d > 1) ? $clog2(n / d) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_addsub_digit_adder.sv
// D-bit ripple slice built from full-adder cells.
// c_msb_in exposes the carry entering the slice's top bit.
module digit_adder #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         c_in,
  output logic [D-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [D:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < D; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i])
                   | (a[i] & c[i])
                   | (b[i] & c[i]);
  end

  assign c_out    = c[D];
  assign c_msb_in = c[D-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// N-bit add/sub computed D bits per cycle over N/D RUN cycles.
// ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int DIGITS = digits_f(N, D);
  localparam int CW     = cnt_w_f(N, D);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  if (N % D != 0) begin : g_bad_d
    $error("N must be a multiple of D");
  end
  if (N < 2) begin : g_bad_n
    $error("N must be at least 2");
  end

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [D-1:0]  d_sum;
  logic          d_cout;
  logic          d_cmsb;
  logic [N-1:0]  acc_nx;
  logic [N-1:0]  a_nx;
  logic [N-1:0]  b_nx;
  logic [N-1:0]  res_fin;
  logic          ovf_nx;

  digit_adder #(.D(D)) u_slice (
    .a        (a_reg[D-1:0]),
    .b        (b_reg[D-1:0]),
    .c_in     (carry),
    .sum      (d_sum),
    .c_out    (d_cout),
    .c_msb_in (d_cmsb)
  );

  // Sum digits enter at the top so the last digit lands in the MSBs.
  if (D == N) begin : g_one
    assign acc_nx = d_sum;
    assign a_nx   = '0;
    assign b_nx   = '0;
  end else begin : g_many
    assign acc_nx = {d_sum, acc[N-1:D]};
    assign a_nx   = {{D{1'b0}}, a_reg[N-1:D]};
    assign b_nx   = {{D{1'b0}}, b_reg[N-1:D]};
  end

  assign ovf_nx = d_cmsb ^ d_cout;

`ifdef ADDSUB_SAT_EN
  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  // On overflow the wrapped sign bit is the inverse of the true sign.
  always_comb begin
    res_fin = acc_nx;
    if (ovf_nx) begin
      res_fin = acc_nx[N-1] ? SMAX : SMIN;
    end
  end
`else
  assign res_fin = acc_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          a_reg <= a_nx;
          b_reg <= b_nx;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= res_fin;
            c_out  <= d_cout;
            ovf    <= ovf_nx;
            zero   <= (res_fin == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench: four instances (D=1,2,4,8, N=8) on shared inputs vs a
// cycle-level arithmetic model, plus literal checks on D=2.
module tb_digit_serial_addsub;

  typedef struct packed {
    logic       c;
    logic       v;
    logic       z;
    logic [7:0] r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;

  logic       o_busy [4];
  logic       o_done [4];
  logic [7:0] o_res  [4];
  logic       o_c    [4];
  logic       o_v    [4];
  logic       o_z    [4];

  int   n_pass = 0;
  int   n_tot  = 0;
  int   ec     = 0;
  int   se     [4];
  exp_t held   [4];
  exp_t pend   [4];

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_addsub #(.N(8), .D(1 << g)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (o_busy[g]),
      .done   (o_done[g]),
      .result (o_res[g]),
      .c_out  (o_c[g]),
      .ovf    (o_v[g]),
      .zero   (o_z[g])
    );
  end

  function automatic exp_t gold(input logic [7:0] x,
                                input logic [7:0] y,
                                input logic       s);
    exp_t e;
    int   t;
    int   u;
    t = s ? int'($signed(x)) - int'($signed(y))
          : int'($signed(x)) + int'($signed(y));
    u = s ? int'(x) - int'(y) : int'(x) + int'(y);
    e.v = (t > 127) || (t < -128);
    e.c = s ? (x >= y) : (u > 255);
    e.r = t[7:0];
`ifdef ADDSUB_SAT_EN
    if (e.v) e.r = (t > 0) ? 8'h7F : 8'h80;
`endif
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      se[g]   = -1000;
      held[g] = '0;
      pend[g] = '0;
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      int   l;
      int   e;
      exp_t v;
      l = 8 >> g;
      e = ec - se[g];
      v = (e >= l) ? pend[g] : held[g];
      chk($sformatf("D%0d busy", 1 << g), 32'(o_busy[g]),
          32'(e >= 0 && e < l));
      chk($sformatf("D%0d done", 1 << g), 32'(o_done[g]),
          32'(e == l));
      chk($sformatf("D%0d result", 1 << g), 32'(o_res[g]),
          32'(v.r));
      chk($sformatf("D%0d c_out", 1 << g), 32'(o_c[g]),
          32'(v.c));
      chk($sformatf("D%0d ovf", 1 << g), 32'(o_v[g]),
          32'(v.v));
      chk($sformatf("D%0d zero", 1 << g), 32'(o_z[g]),
          32'(v.z));
    end
  endtask

  // One clock: drive at negedge, update model, sample next negedge.
  task automatic step(input logic       st,
                      input logic [7:0] ia,
                      input logic [7:0] ib,
                      input logic       is);
    start = st;
    a     = ia;
    b     = ib;
    sub   = is;
    if (st && rst_n) begin
      for (int g = 0; g < 4; g++) begin
        if (ec - se[g] >= (8 >> g) + 1) begin
          held[g] = pend[g];
          pend[g] = gold(ia, ib, is);
          se[g]   = ec + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Full operation; also measures latency and busy length per instance.
  task automatic do_op(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic       s);
    int lat [4];
    int bc  [4];
    for (int g = 0; g < 4; g++) begin
      lat[g] = -1;
      bc[g]  = 0;
    end
    step(1'b1, x, y, s);
    for (int g = 0; g < 4; g++) bc[g] += int'(o_busy[g]);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, $urandom, $urandom, 1'($urandom));
      for (int g = 0; g < 4; g++) begin
        bc[g] += int'(o_busy[g]);
        if (o_done[g] && lat[g] < 0) lat[g] = k;
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("D%0d latency", 1 << g), 32'(lat[g]),
          32'(8 >> g));
      chk($sformatf("D%0d busy len", 1 << g), 32'(bc[g]),
          32'(8 >> g));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset result", 32'(o_res[1]), 32'h0);
    chk("reset busy", 32'(o_busy[1]), 32'h0);
    check_all();
    rst_n = 1'b1;
    idle(2);

    chk("gold 3C+05", 32'(gold(8'h3C, 8'h05, 1'b0)), 32'h041);
    chk("gold FF+01", 32'(gold(8'hFF, 8'h01, 1'b0)), 32'h500);
    chk("gold 05-05", 32'(gold(8'h05, 8'h05, 1'b1)), 32'h500);

    do_op(8'h3C, 8'h05, 1'b0);
    chk("3C+05 res", 32'(o_res[1]), 32'h41);
    chk("3C+05 flags", {29'd0, o_c[1], o_v[1], o_z[1]}, 32'h0);

    do_op(8'h05, 8'h05, 1'b1);
    chk("05-05 res", 32'(o_res[1]), 32'h00);
    chk("05-05 flags", {29'd0, o_c[1], o_v[1], o_z[1]}, 32'h5);

    do_op(8'hFF, 8'h01, 1'b0);
    chk("FF+01 res", 32'(o_res[1]), 32'h00);
    chk("FF+01 flags", {29'd0, o_c[1], o_v[1], o_z[1]}, 32'h5);

    do_op(8'h80, 8'h01, 1'b1);
    chk("80-01 flags", {29'd0, o_c[1], o_v[1], o_z[1]}, 32'h6);
`ifdef ADDSUB_SAT_EN
    chk("80-01 res", 32'(o_res[1]), 32'h80);
`else
    chk("80-01 res", 32'(o_res[1]), 32'h7F);
`endif

    do_op(8'h7F, 8'h01, 1'b0);
    chk("7F+01 flags", {29'd0, o_c[1], o_v[1], o_z[1]}, 32'h2);
`ifdef ADDSUB_SAT_EN
    chk("7F+01 res", 32'(o_res[1]), 32'h7F);
`else
    chk("7F+01 res", 32'(o_res[1]), 32'h80);
`endif

    step(1'b1, 8'h12, 8'h34, 1'b0);
    step(1'b1, 8'hAA, 8'h11, 1'b1);
    step(1'b1, 8'hAA, 8'h11, 1'b1);
    idle(10);
    chk("ignore res", 32'(o_res[1]), 32'h46);

    step(1'b1, 8'h21, 8'h43, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("D%0d rst outs", 1 << g),
          {26'd0, o_busy[g], o_done[g], o_c[g], o_v[g], o_z[g],
           1'b0} | 32'(o_res[g]), 32'h0);
    end
    model_reset();
    rst_n = 1'b1;
    idle(12);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0), 8'($urandom),
           8'($urandom), 1'($urandom));
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
